// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - bus transfer sequencer: drive/sample/turnaround FSM; optional transfer counter under BUS_XFER_CNT_EN
module bus_xfer_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DRIVE_CYC = 1,
  parameter int TURN_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              send,
  output logic [DATA_W-1:0] data_to_bus,
  output logic              rcv,
  input  logic [DATA_W-1:0] data_from_bus,
  output logic              busy,
  output logic [7:0]        xfer_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_t;

  // Cycle counter holds "cycles remaining minus one" in the current state.
  localparam logic [3:0] DRIVE_LOAD = 4'(DRIVE_CYC - 1);
  localparam logic [3:0] TURN_LOAD  = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;
  // With no turnaround configured a finished transfer goes straight back to IDLE.
  localparam state_t DONE_STATE = (TURN_CYC > 0) ? TURN : IDLE;

  state_t     state, state_nxt;
  logic [3:0] cyc_cnt, cyc_nxt;

  // Control outputs are pure decodes of the registered state; rd_ready also
  // drops while a write is offered so the write wins in IDLE.
  assign wr_ready = (state == IDLE);
  assign rd_ready = (state == IDLE) && !wr_valid;
  assign send     = (state == DRIVE);
  assign rcv      = (state == SAMPLE);
  assign busy     = (state != IDLE);

  // State and cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
    end
  end

  // Next-state logic; the counter reloads on every state entry, else counts down.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    case (state)
      IDLE: begin
        if (wr_valid) begin
          state_nxt = DRIVE;
          cyc_nxt   = DRIVE_LOAD;
        end else if (rd_req) begin
          state_nxt = SAMPLE;
          cyc_nxt   = 4'd0;
        end
      end
      DRIVE: begin
        if (cyc_cnt == 4'd0) begin
          state_nxt = DONE_STATE;
          cyc_nxt   = TURN_LOAD;
        end else begin
          cyc_nxt = cyc_cnt - 4'd1;
        end
      end
      SAMPLE: begin
        state_nxt = DONE_STATE;
        cyc_nxt   = TURN_LOAD;
      end
      TURN: begin
        if (cyc_cnt == 4'd0) begin
          state_nxt = IDLE;
          cyc_nxt   = 4'd0;
        end else begin
          cyc_nxt = cyc_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = 4'd0;
      end
    endcase
  end

  // Latch write payload on accept; it stays on the bus lines until the next write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_to_bus <= '0;
    end else if (state == IDLE && wr_valid) begin
      data_to_bus <= wr_data;
    end
  end

  // Capture the bus at the edge that ends SAMPLE and flag it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == SAMPLE);
      if (state == SAMPLE) begin
        rd_data <= data_from_bus;
      end
    end
  end

`ifdef BUS_XFER_CNT_EN
  logic xfer_done;
  assign xfer_done = ((state == DRIVE) && (cyc_cnt == 4'd0)) || (state == SAMPLE);

  // Count completed transfers; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 8'd0;
    end else if (xfer_done) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`else
  assign xfer_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - scoreboard bench for bus_xfer_ctrl (1/1 and 3/0 drive/turn configurations)
module tb_bus_xfer_ctrl;

  localparam int DW  = 8;
  localparam int DRV = 1;
  localparam int TRN = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, rd_req;
  logic [DW-1:0] wr_data, data_from_bus;
  logic          wr_ready, rd_ready, rd_valid, send, rcv, busy;
  logic [DW-1:0] rd_data, data_to_bus;
  logic [7:0]    xfer_cnt;

  logic          b_wr_valid, b_rd_req;
  logic [DW-1:0] b_wr_data, b_data_from_bus;
  logic          b_wr_ready, b_rd_ready, b_rd_valid, b_send, b_rcv, b_busy;
  logic [DW-1:0] b_rd_data, b_data_to_bus;
  logic [7:0]    b_xfer_cnt;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.DATA_W(DW), .DRIVE_CYC(DRV), .TURN_CYC(TRN)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .send(send), .data_to_bus(data_to_bus), .rcv(rcv), .data_from_bus(data_from_bus),
    .busy(busy), .xfer_cnt(xfer_cnt));

  bus_xfer_ctrl #(.DATA_W(DW), .DRIVE_CYC(3), .TURN_CYC(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_req(b_rd_req), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .send(b_send), .data_to_bus(b_data_to_bus), .rcv(b_rcv), .data_from_bus(b_data_from_bus),
    .busy(b_busy), .xfer_cnt(b_xfer_cnt));

  typedef struct packed {
    logic          is_wr;
    logic [DW-1:0] data;
  } xfer_t;

  xfer_t         exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            send_run, rcv_run, gap, done_cnt;
  bit            post_active, prev_rdv;
  logic [DW-1:0] last_wr, last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef BUS_XFER_CNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Monitor: pops the scoreboard at each completed transfer and checks bus-level rules.
  always @(negedge clk) begin
    xfer_t item;
    if (!rst_n) begin
      exp_q.delete();
      send_run = 0; rcv_run = 0; gap = 0; done_cnt = 0;
      post_active = 0; prev_rdv = 0; last_wr = '0; last_rd = '0;
    end else begin
      check("send_rcv_overlap", {31'd0, send && rcv}, 32'd0);
      check("wr_ready_vs_busy", {31'd0, wr_ready}, {31'd0, !busy});
      check("rd_ready_vs_wr_valid", {31'd0, rd_ready}, {31'd0, wr_ready && !wr_valid});
      if (send) begin
        send_run++;
      end else if (send_run > 0) begin
        if (exp_q.size() == 0) begin
          check("send_without_write", send_run, 0);
        end else begin
          item = exp_q.pop_front();
          check("xfer_kind_write", {31'd0, item.is_wr}, 32'd1);
          check("send_len", send_run, DRV);
          check("data_to_bus", {24'd0, data_to_bus}, {24'd0, item.data});
          last_wr = item.data;
          done_cnt++;
          check("xfer_cnt_after_write", {24'd0, xfer_cnt}, {24'd0, exp_cnt(done_cnt)});
        end
        send_run = 0; post_active = 1; gap = 0;
      end
      if (!send) check("data_to_bus_hold", {24'd0, data_to_bus}, {24'd0, last_wr});
      if (rcv) begin
        rcv_run++;
      end else if (rcv_run > 0) begin
        check("rcv_len", rcv_run, 1);
        rcv_run = 0;
      end
      if (rd_valid) begin
        check("rd_valid_one_cycle", {31'd0, prev_rdv}, 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
          item = exp_q.pop_front();
          check("xfer_kind_read", {31'd0, item.is_wr}, 32'd0);
          check("rd_data", {24'd0, rd_data}, {24'd0, item.data});
          last_rd = item.data;
          done_cnt++;
          check("xfer_cnt_after_read", {24'd0, xfer_cnt}, {24'd0, exp_cnt(done_cnt)});
        end
        post_active = 1; gap = 0;
      end else begin
        check("rd_data_hold", {24'd0, rd_data}, {24'd0, last_rd});
      end
      prev_rdv = rd_valid;
      if (post_active) begin
        if (wr_ready) begin
          check("turnaround_gap", gap, TRN);
          post_active = 0;
        end else begin
          gap++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a write and/or read; returns #1 after the write accept edge, or after
  // the edge that ends SAMPLE for a read.
  task automatic req(input bit w, input bit r, input logic [DW-1:0] wd, input logic [DW-1:0] bd);
    int t;
    wr_valid = w; wr_data = wd; rd_req = r; data_from_bus = bd;
    t = 0;
    while ((wr_valid || rd_req) && t < 60) begin
      @(negedge clk);
      t++;
      if (wr_valid && wr_ready) begin
        check("read_held_off", {31'd0, rd_ready}, 32'd0);
        check("sb_empty_at_accept", exp_q.size(), 0);
        exp_q.push_back('{is_wr: 1'b1, data: wd});
        step();
        wr_valid = 1'b0;
        if (!rd_req) return;
      end else if (rd_req && rd_ready) begin
        check("sb_empty_at_accept", exp_q.size(), 0);
        exp_q.push_back('{is_wr: 1'b0, data: bd});
        step();
        rd_req = 1'b0;
        step();
      end
    end
    if (wr_valid || rd_req) check("accept_timeout", {31'd0, wr_valid | rd_req}, 32'd0);
    wr_valid = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !busy && !post_active) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    step();
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    wr_valid = 0; rd_req = 0; wr_data = '0; data_from_bus = '0;
    b_wr_valid = 0; b_rd_req = 0; b_wr_data = '0; b_data_from_bus = '0;
    #12;
    check("rst_send", {31'd0, send}, 0);
    check("rst_rcv", {31'd0, rcv}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_data_to_bus", {24'd0, data_to_bus}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    check("rst_xfer_cnt", {24'd0, xfer_cnt}, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_ready_after_reset", {31'd0, wr_ready}, 1);
    step();

    // Single write: one DRIVE cycle, one TURN cycle, then ready again.
    req(1, 0, 8'hA5, 8'h00);
    check("w_send_hi", {31'd0, send}, 1);
    check("w_data_to_bus", {24'd0, data_to_bus}, 32'hA5);
    check("w_wr_ready_lo", {31'd0, wr_ready}, 0);
    step();
    check("w_turn_send_lo", {31'd0, send}, 0);
    check("w_turn_busy", {31'd0, busy}, 1);
    step();
    check("w_wr_ready_back", {31'd0, wr_ready}, 1);

    // Single read.
    req(0, 1, 8'h00, 8'h3C);
    check("r_rd_valid", {31'd0, rd_valid}, 1);
    check("r_rd_data", {24'd0, rd_data}, 32'h3C);
    step();
    check("r_rd_valid_drop", {31'd0, rd_valid}, 0);

    // Simultaneous write and read: write first, read after its turnaround.
    req(1, 1, 8'h96, 8'h69);
    wait_idle();

    // Randomized mix of writes, reads and collisions with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 2);
      req(k != 1, k != 0, 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();

    // Reset during SAMPLE aborts the read.
    rd_req = 1'b1; data_from_bus = 8'hE7;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rd_ready && k < 20);
    step();
    rd_req = 1'b0;
    check("abort_in_sample", {31'd0, rcv}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rcv", {31'd0, rcv}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rd_valid", {31'd0, rd_valid}, 0);
    check("abort_xfer_cnt", {24'd0, xfer_cnt}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_rd_valid", {31'd0, rd_valid}, 0);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rd_valid_post", {31'd0, rd_valid}, 0);
    check("wr_ready_after_abort", {31'd0, wr_ready}, 1);
    step();

    // 256 writes bring the counter back to its starting value.
    for (int i = 0; i < 256; i++) req(1, 0, 8'($urandom), 8'h00);
    wait_idle();
    check("xfer_cnt_wrap", {24'd0, xfer_cnt}, {24'd0, exp_cnt(256)});
    req(1, 0, 8'h11, 8'h00);
    wait_idle();
    check("xfer_cnt_after_wrap", {24'd0, xfer_cnt}, {24'd0, exp_cnt(257)});

    // DRIVE_CYC=3, TURN_CYC=0 instance.
    b_wr_valid = 1'b1; b_wr_data = 8'h5A;
    @(negedge clk);
    check("p_wr_ready", {31'd0, b_wr_ready}, 1);
    step();
    b_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("p_send_hi", {31'd0, b_send}, 1);
      check("p_data_to_bus", {24'd0, b_data_to_bus}, 32'h5A);
      step();
    end
    check("p_send_lo", {31'd0, b_send}, 0);
    check("p_wr_ready_next", {31'd0, b_wr_ready}, 1);
    check("p_xfer_cnt_w", {24'd0, b_xfer_cnt}, {24'd0, exp_cnt(1)});
    b_rd_req = 1'b1; b_data_from_bus = 8'hC3;
    @(negedge clk);
    check("p_rd_ready", {31'd0, b_rd_ready}, 1);
    step();
    b_rd_req = 1'b0;
    check("p_rcv_hi", {31'd0, b_rcv}, 1);
    check("p_send_off_in_sample", {31'd0, b_send}, 0);
    step();
    check("p_rcv_lo", {31'd0, b_rcv}, 0);
    check("p_rd_valid", {31'd0, b_rd_valid}, 1);
    check("p_rd_data", {24'd0, b_rd_data}, 32'hC3);
    check("p_no_turn", {31'd0, b_wr_ready}, 1);
    check("p_xfer_cnt_r", {24'd0, b_xfer_cnt}, {24'd0, exp_cnt(2)});
    step();
    check("p_rd_valid_drop", {31'd0, b_rd_valid}, 0);
    check("p_rd_data_hold", {24'd0, b_rd_data}, 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
